// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Serial bit-pattern detector with a runtime-programmable pattern of
//   1..MAX_LEN bits. Each accepted bit is shifted into a history register,
//   and the last len bits are compared against the active pattern. A match
//   gives a registered one-cycle pulse and bumps a saturating counter.
//   Overlapping or non-overlapping detection is selectable.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     in_bit is accepted on this edge
//   in_bit       serial data bit
//   cfg_load     latch cfg_* and clear history (has priority over in_valid)
//   cfg_pattern  new pattern, LSB-aligned; bit [len-1] is the first bit received
//   cfg_len      new pattern length
//   cfg_overlap  1 = overlapping detection, 0 = non-overlapping
//   cnt_clr      clear match counter (a hit on the same edge gives 1)
//   match        registered one-cycle match pulse
//   match_count  saturating match count
//   cfg_err      active length is 0 or above MAX_LEN; detector disabled
//
// Handshake: in_valid is a qualifier only. There is no back-pressure, and
//   one bit may be accepted every cycle.
module seq_detector_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1011,
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b1,
  localparam int                LW          = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam bit DEF_ERR = (DEF_LEN == 0) || (DEF_LEN > MAX_LEN);

  // state registers
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  // datapath helpers
  logic [MAX_LEN-1:0] hist_sh;
  logic [LW-1:0]      fill_inc;
  logic [MAX_LEN-1:0] mask;
  logic               accept;
  logic               hit;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= DEF_PATTERN;
      len_q   <= LW'(DEF_LEN);
      ovl_q   <= DEF_OVERLAP;
      match_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= DEF_ERR;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // match evaluation on the would-be next history
  always_comb begin
    hist_sh  = {hist_q[MAX_LEN-2:0], in_bit};
    fill_inc = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
    accept = in_valid && !cfg_load;
    hit    = accept && !err_q && (fill_inc >= len_q) &&
             (((hist_sh ^ pat_q) & mask) == '0);
  end

  // next-state logic
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    match_d = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;

    if (cfg_load) begin
      // A bit presented on the load edge is dropped; history restarts empty.
      pat_d  = cfg_pattern;
      len_d  = cfg_len;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
      err_d  = (cfg_len == '0) || (int'(cfg_len) > MAX_LEN);
    end else if (in_valid) begin
      hist_d  = hist_sh;
      match_d = hit;
      // Non-overlap: forget the matched bits so the next hit needs len new ones.
      fill_d  = (hit && !ovl_q) ? '0 : fill_inc;
    end

    if (cnt_clr) begin
      cnt_d = hit ? CNT_W'(1) : '0;
    end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // outputs
  always_comb begin
    match       = match_q;
    match_count = cnt_q;
    cfg_err     = err_q;
  end

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LW      = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  // main DUT (defaults)
  logic               in_valid = 1'b0, in_bit = 1'b0, cfg_load = 1'b0, cnt_clr = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LW-1:0]      cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               match;
  logic [7:0]         match_count;
  logic               cfg_err;

  seq_detector_param dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .match(match),
    .match_count(match_count), .cfg_err(cfg_err)
  );

  // second DUT with a 2-bit counter for saturation checks
  logic               in_valid2 = 1'b0, in_bit2 = 1'b0, cfg_load2 = 1'b0, cnt_clr2 = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern2 = '0;
  logic [LW-1:0]      cfg_len2 = '0;
  logic               cfg_overlap2 = 1'b0;
  logic               match2;
  logic [1:0]         match_count2;
  logic               cfg_err2;

  seq_detector_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_bit(in_bit2),
    .cfg_load(cfg_load2), .cfg_pattern(cfg_pattern2), .cfg_len(cfg_len2),
    .cfg_overlap(cfg_overlap2), .cnt_clr(cnt_clr2), .match(match2),
    .match_count(match_count2), .cfg_err(cfg_err2)
  );

  // scoreboard: each entry is {edge index at which match must be seen, count}
  logic [31:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: every match pulse must correspond to the head of the queue
  always @(posedge clk) begin
    logic [31:0] e;
    logic [31:0] got;
    #1;
    cyc = cyc + 1;
    if (match === 1'b1) begin
      n_chk++;
      got = {cyc[23:0], match_count};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_match: at edge %0d count %0d, none expected", cyc, match_count);
      end else begin
        e = exp_q.pop_front();
        if (got != e) begin
          n_fail++;
          $display("FAIL match_pop: got edge %0d count %0d expected edge %0d count %0d",
                   got[31:8], got[7:0], e[31:8], e[7:0]);
        end
      end
    end
  end

  // driver tasks (main DUT)
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    end
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic send(input logic b, input logic exp_m, input int exp_cnt);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; in_bit = b; cfg_load = 1'b0; cnt_clr = 1'b0;
    if (exp_m) exp_q.push_back({cyc[23:0] + 24'd1, exp_cnt[7:0]});
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o,
                      input logic clr, input logic v, input logic b);
    @(negedge clk);
    rst = 1'b0; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    cfg_load = 1'b1; cnt_clr = clr; in_valid = v; in_bit = b;
  endtask

  // driver task (second DUT), checks right after the edge
  task automatic send2(input logic b, input logic clr, input logic exp_m, input int exp_cnt);
    @(negedge clk);
    in_valid2 = 1'b1; in_bit2 = b; cnt_clr2 = clr; cfg_load2 = 1'b0;
    @(posedge clk);
    #2;
    check("sat_match", int'(match2), int'(exp_m));
    check("sat_count", int'(match_count2), exp_cnt);
  endtask

  initial begin
    logic [7:0] a5;
    // reset
    do_rst();
    do_rst();
    idle(1);
    check("rst_match", int'(match), 0);
    check("rst_count", int'(match_count), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_count2", int'(match_count2), 0);

    // default pattern 1011, len 4
    send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(1, 1, 1);
    idle(2);
    check("def_count", int'(match_count), 1);
    check("def_cfg_err", int'(cfg_err), 0);
    check("def_q_empty", exp_q.size(), 0);

    // overlap: 101 on 1010101 -> hits at bits 3,5,7
    load(8'b101, 3, 1'b1, 1'b1, 1'b0, 1'b0);
    send(1, 0, 0); send(0, 0, 0); send(1, 1, 1); send(0, 0, 0);
    send(1, 1, 2); send(0, 0, 0); send(1, 1, 3);
    idle(2);
    check("ovl_count", int'(match_count), 3);

    // non-overlap: same stream -> hits at bits 3,7
    load(8'b101, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    send(1, 0, 0); send(0, 0, 0); send(1, 1, 1); send(0, 0, 0);
    send(1, 0, 0); send(0, 0, 0); send(1, 1, 2);
    idle(2);
    check("novl_count", int'(match_count), 2);
    check("novl_q_empty", exp_q.size(), 0);

    // full length 8'hA5 with random gaps
    load(8'hA5, 8, 1'b1, 1'b1, 1'b0, 1'b0);
    a5 = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      idle($urandom_range(0, 2));
      send(a5[i], (i == 0), 1);
    end
    idle(2);
    check("full_count", int'(match_count), 1);
    check("full_q_empty", exp_q.size(), 0);

    // invalid lengths: 0 and 9
    load(8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("len0_cfg_err", int'(cfg_err), 1);
    send(1, 0, 0); send(1, 0, 0); send(0, 0, 0); send(1, 0, 0);
    send(0, 0, 0); send(1, 0, 0); send(1, 0, 0); send(0, 0, 0);
    load(8'hFF, 9, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("len9_cfg_err", int'(cfg_err), 1);
    for (int i = 0; i < 9; i++) send(1, 0, 0);
    load(8'h0B, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("reload_cfg_err", int'(cfg_err), 0);
    check("inv_count_kept", int'(match_count), 1);
    check("inv_q_empty", exp_q.size(), 0);

    // rst mid-sequence discards history (and clears the counter)
    send(1, 0, 0); send(0, 0, 0); send(1, 0, 0);
    do_rst();
    send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(1, 1, 1);
    idle(2);
    check("rst_mid_count", int'(match_count), 1);

    // cfg_load with in_valid: the bit is dropped and history restarts
    send(1, 0, 0); send(0, 0, 0); send(1, 0, 0);
    load(8'h0B, 4, 1'b1, 1'b0, 1'b1, 1'b1);
    send(0, 0, 0); send(1, 0, 0); send(1, 0, 0);
    send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(1, 1, 2);
    idle(2);
    check("drop_count", int'(match_count), 2);
    check("drop_q_empty", exp_q.size(), 0);

    // counter saturation on the 2-bit instance: pattern 1, len 1
    @(negedge clk);
    cfg_pattern2 = 8'h01; cfg_len2 = 4'd1; cfg_overlap2 = 1'b1; cfg_load2 = 1'b1;
    @(negedge clk);
    cfg_load2 = 1'b0;
    check("sat_cfg_err", int'(cfg_err2), 0);
    send2(1, 0, 1, 1);
    send2(1, 0, 1, 2);
    send2(1, 0, 1, 3);
    send2(1, 0, 1, 3);
    send2(1, 0, 1, 3);
    send2(1, 1, 1, 1);  // clear together with a hit
    send2(0, 1, 0, 0);  // clear without a hit
    @(negedge clk);
    in_valid2 = 1'b0; cnt_clr2 = 1'b0;

    idle(3);
    check("final_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector, the next generation of the fixed-pattern detector. It samples a qualified serial bit stream and compares it against a runtime-programmable pattern of 1..MAX_LEN bits. Matches are reported as a registered one-cycle pulse, with overlapping or non-overlapping detection selectable, and counted in a saturating match counter. It sits directly behind a serial receive front-end and feeds frame-sync and status logic.

## Interface
- MAX_LEN, 8: maximum pattern length in bits, ≥ 2.
- CNT_W, 8: match counter width.
- DEF_PATTERN, 8'b0000_1011: pattern loaded at reset, LSB-aligned, MAX_LEN bits wide.
- DEF_LEN, 4: pattern length loaded at reset.
- DEF_OVERLAP, 1: overlap mode loaded at reset.
- LW = $clog2(MAX_LEN+1): localparam, length field width.

- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_bit is sampled on this edge.
- in_bit  in  1  serial data bit.
- cfg_load  in  1  latch cfg_* on this edge and clear history.
- cfg_pattern  in  MAX_LEN  new pattern, LSB-aligned. Bit [len-1] is the first bit received; bit 0 is the last.
- cfg_len  in  LW  new length.
- cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping.
- cnt_clr  in  1  clear match counter.
- match  out  1  registered one-cycle match pulse.
- match_count  out  CNT_W  saturating number of matches.
- cfg_err  out  1  active config length is invalid; detector disabled.

## Operation
- Registers:
  - hist[MAX_LEN-1:0]: shift history.
  - fill[LW-1:0]: valid history bits, saturating at MAX_LEN.
  - pat, len, ovl: active configuration.
  - match, match_count, cfg_err.
- Reset (rst=1 at an edge): hist=0, fill=0, pat=DEF_PATTERN, len=DEF_LEN, ovl=DEF_OVERLAP, match=0, match_count=0, cfg_err=(DEF_LEN==0 || DEF_LEN>MAX_LEN).
- Config load (cfg_load=1, no rst):
  - pat/len/ovl take cfg_* values; hist=0, fill=0, match=0.
  - cfg_err = (cfg_len==0 || cfg_len>MAX_LEN).
  - A simultaneous in_valid bit is dropped.
  - match_count is unaffected.
- Bit accept (in_valid=1, no rst, no cfg_load):
  - hist_n = {hist[MAX_LEN-2:0], in_bit}.
  - fill_n = min(fill+1, MAX_LEN).
  - hit = !cfg_err && fill_n ≥ len && (hist_n & mask) == (pat & mask), where mask = (1<<len)-1.
  - match <= hit.
  - If hit and ovl=0: fill <= 0, so the matched bits cannot be reused. Otherwise fill <= fill_n.
  - hist <= hist_n in all cases.
- No in_valid: match <= 0; hist and fill hold.
- Counter:
  - On hit, match_count increments, saturating at 2^CNT_W-1.
  - cnt_clr has priority over an increment without hit: count <= 0.
  - cnt_clr together with hit: count <= 1.
  - rst clears the counter; cfg_load does not.
- Priority: rst > cfg_load > in_valid.
- Pattern bits above len are ignored.
- len == MAX_LEN is legal and uses the full history.

## Timing
- Latency: the last pattern bit is sampled at edge k; match is high for the cycle following edge k, exactly one cycle wide.
- match_count reflects the hit from the same edge k.
- Back-to-back in_valid is supported at one bit per cycle. Gaps in in_valid do not break a sequence in progress.
- Overlap mode:
  - After the first match, a further match can occur as soon as the last len accepted bits again equal the pattern.
  - Example: pattern 11, stream 111 gives 2 matches.
- Non-overlap mode: the next match needs len fresh bits after the hit.
- The new config is effective for the first bit accepted after the cfg_load edge.
- rst mid-sequence discards all partial history; the first possible match needs len new bits.

## Test plan
- Reset defaults:
  - Stimulus: stream 1,0,1,1 with in_valid held high.
  - Response: match pulses for one cycle after the 4th bit; match_count=1; cfg_err=0.
- Overlap vs. non-overlap:
  - Stimulus: load pattern 3'b101, len 3, stream 1,0,1,0,1.
  - Response with ovl=1: matches after bits 3 and 5, count 2.
  - Response with ovl=0: match after bit 3 only, count 1.
- Full length and gaps:
  - Stimulus: MAX_LEN=8 pattern 8'hA5 fed with random in_valid gaps.
  - Response: exactly one match after the 8th accepted bit; no match on the 7 preceding bits.
- Invalid config:
  - Stimulus: cfg_len=0, then cfg_len=9.
  - Response: cfg_err=1 in both cases; no match on any stream.
  - Stimulus: reload len 4.
  - Response: cfg_err=0.
- Counter saturation and clear:
  - Setup: CNT_W=2, pattern 1 with len 1, overlap.
  - Stimulus: five 1s.
  - Response: count stops at 3.
  - Stimulus: cnt_clr on the same edge as a hit.
  - Response: count=1.
- Mid-operation events:
  - Stimulus: rst after 1,0,1, then 1.
  - Response: no match.
  - Stimulus: cfg_load asserted on the same edge as in_valid.
  - Response: that bit is dropped and fill=0.
